// File: rtl/apb2axi_dir.sv
// Transaction directory for the APB-to-AXI bridge: tags committed commands, issues them in
// commit order, tracks AXI completion and offers finished entries to the status path.
module apb2axi_dir #(
    parameter int unsigned AXI_ADDR_W = 64,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TAG_W      = $clog2(DEPTH)
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  commit_pulse,
    input  logic [AXI_ADDR_W-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic                  is_write,
    output logic                  dir_full,
    output logic                  commit_drop,
    output logic [7:0]            drop_cnt,
    output logic [TAG_W:0]        free_cnt,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [TAG_W-1:0]      issue_tag,
    output logic [AXI_ADDR_W-1:0] issue_addr,
    output logic [7:0]            issue_len,
    output logic [2:0]            issue_size,
    output logic                  issue_is_write,
    input  logic                  cpl_valid,
    input  logic [TAG_W-1:0]      cpl_tag,
    input  logic                  cpl_err,
    output logic                  spurious_cpl,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [TAG_W-1:0]      done_tag,
    output logic                  done_err
);

    localparam logic [1:0] StFree    = 2'd0;
    localparam logic [1:0] StPending = 2'd1;
    localparam logic [1:0] StIssued  = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    // Per-entry lifecycle state and completion status
    logic [1:0]            state_q [DEPTH];
    logic [1:0]            state_d [DEPTH];
    logic                  err_q   [DEPTH];

    // Command payload; only ever read while the entry is PENDING, so it needs no reset
    logic [AXI_ADDR_W-1:0] addr_q  [DEPTH];
    logic [7:0]            len_q   [DEPTH];
    logic [2:0]            size_q  [DEPTH];
    logic                  wr_q    [DEPTH];

    // In-order issue FIFO of tags; it holds exactly the PENDING entries, so it cannot overflow
    logic [TAG_W-1:0]      fifo_q  [DEPTH];
    logic [TAG_W-1:0]      rd_ptr_q;
    logic [TAG_W-1:0]      wr_ptr_q;
    logic [TAG_W:0]        fifo_cnt_q;
    logic [TAG_W:0]        fifo_cnt_d;

    logic                  dir_full_q;
    logic                  dir_full_d;
    logic [TAG_W:0]        free_cnt_q;
    logic [TAG_W:0]        free_cnt_d;
    logic                  commit_drop_q;
    logic [7:0]            drop_cnt_q;
    logic [7:0]            drop_cnt_d;
    logic                  spurious_q;

    logic                  alloc_found;
    logic [TAG_W-1:0]      alloc_tag;
    logic                  done_any;
    logic [TAG_W-1:0]      done_sel;
    logic [TAG_W-1:0]      head_tag;
    logic                  commit_ok;
    logic                  commit_rej;
    logic                  issue_fire;
    logic                  cpl_ok;
    logic                  done_fire;

    always_comb begin
        alloc_found = 1'b0;
        alloc_tag   = '0;
        done_any    = 1'b0;
        done_sel    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!alloc_found && state_q[i] == StFree) begin
                alloc_found = 1'b1;
                alloc_tag   = TAG_W'(i);
            end
            if (!done_any && state_q[i] == StDone) begin
                done_any = 1'b1;
                done_sel = TAG_W'(i);
            end
        end
    end

    assign head_tag    = fifo_q[rd_ptr_q];
    assign issue_valid = (fifo_cnt_q != '0);
    assign issue_fire  = issue_valid && issue_ready;

    // Admission uses the registered full flag only; a same-cycle free does not help
    assign commit_ok  = commit_pulse && !dir_full_q && alloc_found;
    assign commit_rej = commit_pulse && dir_full_q;
    assign cpl_ok     = cpl_valid && (state_q[cpl_tag] == StIssued);
    assign done_fire  = done_any && done_ready;

    // All four events touch entries in distinct states, so they never collide on one index
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            state_d[i] = state_q[i];
        end
        if (commit_ok) begin
            state_d[alloc_tag] = StPending;
        end
        if (issue_fire) begin
            state_d[head_tag] = StIssued;
        end
        if (cpl_ok) begin
            state_d[cpl_tag] = StDone;
        end
        if (done_fire) begin
            state_d[done_sel] = StFree;
        end
    end

    always_comb begin
        free_cnt_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (state_d[i] == StFree) begin
                free_cnt_d = free_cnt_d + (TAG_W + 1)'(1);
            end
        end
        dir_full_d = (free_cnt_d == '0);
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (commit_ok && !issue_fire) begin
            fifo_cnt_d = fifo_cnt_q + (TAG_W + 1)'(1);
        end else if (!commit_ok && issue_fire) begin
            fifo_cnt_d = fifo_cnt_q - (TAG_W + 1)'(1);
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (commit_rej && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                state_q[i] <= StFree;
                err_q[i]   <= 1'b0;
                fifo_q[i]  <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            dir_full_q    <= 1'b0;
            free_cnt_q    <= (TAG_W + 1)'(DEPTH);
            commit_drop_q <= 1'b0;
            drop_cnt_q    <= '0;
            spurious_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                state_q[i] <= state_d[i];
            end
            if (commit_ok) begin
                err_q[alloc_tag]  <= 1'b0;
                fifo_q[wr_ptr_q]  <= alloc_tag;
                wr_ptr_q          <= wr_ptr_q + TAG_W'(1);
            end
            if (issue_fire) begin
                rd_ptr_q <= rd_ptr_q + TAG_W'(1);
            end
            if (cpl_ok) begin
                err_q[cpl_tag] <= cpl_err;
            end
            fifo_cnt_q    <= fifo_cnt_d;
            dir_full_q    <= dir_full_d;
            free_cnt_q    <= free_cnt_d;
            commit_drop_q <= commit_rej;
            drop_cnt_q    <= drop_cnt_d;
            spurious_q    <= cpl_valid && !cpl_ok;
        end
    end

    always_ff @(posedge pclk) begin
        if (commit_ok) begin
            addr_q[alloc_tag] <= addr;
            len_q[alloc_tag]  <= len;
            size_q[alloc_tag] <= size;
            wr_q[alloc_tag]   <= is_write;
        end
    end

    assign dir_full     = dir_full_q;
    assign free_cnt     = free_cnt_q;
    assign commit_drop  = commit_drop_q;
    assign drop_cnt     = drop_cnt_q;
    assign spurious_cpl = spurious_q;

    // Offered fields are forced to zero when nothing is offered so reset leaves them quiet
    always_comb begin
        issue_tag      = '0;
        issue_addr     = '0;
        issue_len      = '0;
        issue_size     = '0;
        issue_is_write = 1'b0;
        if (issue_valid) begin
            issue_tag      = head_tag;
            issue_addr     = addr_q[head_tag];
            issue_len      = len_q[head_tag];
            issue_size     = size_q[head_tag];
            issue_is_write = wr_q[head_tag];
        end
    end

    assign done_valid = done_any;
    assign done_tag   = done_sel;
    assign done_err   = done_any && err_q[done_sel];

endmodule

// File: tb/tb_apb2axi_dir.sv
// Bench for apb2axi_dir: queue/array reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_apb2axi_dir;

    localparam int D = 8;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        commit_pulse = 1'b0;
    logic [63:0] addr = '0;
    logic [7:0]  len = '0;
    logic [2:0]  size = '0;
    logic        is_write = 1'b0;
    logic        issue_ready = 1'b0;
    logic        cpl_valid = 1'b0;
    logic [2:0]  cpl_tag = '0;
    logic        cpl_err = 1'b0;
    logic        done_ready = 1'b0;

    logic        dir_full;
    logic        commit_drop;
    logic [7:0]  drop_cnt;
    logic [3:0]  free_cnt;
    logic        issue_valid;
    logic [2:0]  issue_tag;
    logic [63:0] issue_addr;
    logic [7:0]  issue_len;
    logic [2:0]  issue_size;
    logic        issue_is_write;
    logic        spurious_cpl;
    logic        done_valid;
    logic [2:0]  done_tag;
    logic        done_err;

    int errs = 0;
    int checks = 0;

    apb2axi_dir #(
        .AXI_ADDR_W(64),
        .DEPTH     (8),
        .TAG_W     (3)
    ) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .commit_pulse  (commit_pulse),
        .addr          (addr),
        .len           (len),
        .size          (size),
        .is_write      (is_write),
        .dir_full      (dir_full),
        .commit_drop   (commit_drop),
        .drop_cnt      (drop_cnt),
        .free_cnt      (free_cnt),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_tag     (issue_tag),
        .issue_addr    (issue_addr),
        .issue_len     (issue_len),
        .issue_size    (issue_size),
        .issue_is_write(issue_is_write),
        .cpl_valid     (cpl_valid),
        .cpl_tag       (cpl_tag),
        .cpl_err       (cpl_err),
        .spurious_cpl  (spurious_cpl),
        .done_valid    (done_valid),
        .done_ready    (done_ready),
        .done_tag      (done_tag),
        .done_err      (done_err)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: 0 free, 1 pending, 2 issued, 3 done
    int          m_state [D];
    logic [63:0] m_addr  [D];
    logic [7:0]  m_len   [D];
    logic [2:0]  m_size  [D];
    logic        m_wr    [D];
    logic        m_err   [D];
    int          m_q[$];
    logic        m_drop;
    logic [7:0]  m_drop_cnt;
    logic        m_spur;

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_state[i] = 0;
            m_err[i]   = 1'b0;
        end
        m_q.delete();
        m_drop     = 1'b0;
        m_drop_cnt = '0;
        m_spur     = 1'b0;
    endtask

    task automatic model_step();
        int  alloc;
        int  dsel;
        bit  ifire;
        bit  cok;
        bit  dfire;
        alloc = -1;
        dsel  = -1;
        for (int i = 0; i < D; i++) begin
            if (m_state[i] == 0 && alloc < 0) alloc = i;
            if (m_state[i] == 3 && dsel < 0) dsel = i;
        end
        ifire = (m_q.size() > 0) && issue_ready;
        dfire = (dsel >= 0) && done_ready;
        cok   = cpl_valid && (m_state[cpl_tag] == 2);
        m_drop = commit_pulse && (alloc < 0);
        if (m_drop && m_drop_cnt != 8'd255) m_drop_cnt = m_drop_cnt + 8'd1;
        m_spur = cpl_valid && !cok;
        if (ifire) begin
            m_state[m_q[0]] = 2;
            void'(m_q.pop_front());
        end
        if (commit_pulse && alloc >= 0) begin
            m_state[alloc] = 1;
            m_addr[alloc]  = addr;
            m_len[alloc]   = len;
            m_size[alloc]  = size;
            m_wr[alloc]    = is_write;
            m_err[alloc]   = 1'b0;
            m_q.push_back(alloc);
        end
        if (cok) begin
            m_state[cpl_tag] = 3;
            m_err[cpl_tag]   = cpl_err;
        end
        if (dfire) m_state[dsel] = 0;
    endtask

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) model_reset();
        else model_step();
    end

    int c_nfree;
    int c_dsel;
    always @(negedge pclk) begin
        c_nfree = 0;
        c_dsel  = -1;
        for (int i = 0; i < D; i++) begin
            if (m_state[i] == 0) c_nfree++;
            if (m_state[i] == 3 && c_dsel < 0) c_dsel = i;
        end
        check("m_dir_full", 64'(dir_full), 64'(c_nfree == 0));
        check("m_free_cnt", 64'(free_cnt), 64'(c_nfree));
        check("m_commit_drop", 64'(commit_drop), 64'(m_drop));
        check("m_drop_cnt", 64'(drop_cnt), 64'(m_drop_cnt));
        check("m_spurious", 64'(spurious_cpl), 64'(m_spur));
        check("m_issue_valid", 64'(issue_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("m_issue_tag", 64'(issue_tag), 64'(m_q[0]));
            check("m_issue_addr", issue_addr, m_addr[m_q[0]]);
            check("m_issue_len", 64'(issue_len), 64'(m_len[m_q[0]]));
            check("m_issue_size", 64'(issue_size), 64'(m_size[m_q[0]]));
            check("m_issue_wr", 64'(issue_is_write), 64'(m_wr[m_q[0]]));
        end
        check("m_done_valid", 64'(done_valid), 64'(c_dsel >= 0));
        if (c_dsel >= 0) begin
            check("m_done_tag", 64'(done_tag), 64'(c_dsel));
            check("m_done_err", 64'(done_err), 64'(m_err[c_dsel]));
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    int iss[$];

    initial begin
        step();
        step();
        check("rst_free_cnt", 64'(free_cnt), 64'd8);
        check("rst_dir_full", 64'(dir_full), 64'd0);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_done_valid", 64'(done_valid), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        presetn = 1'b1;
        step();

        // Single command end to end
        issue_ready = 1'b1;
        commit_pulse = 1'b1;
        addr = 64'h0000_0001_0000_1000;
        len = 8'd3;
        size = 3'd2;
        is_write = 1'b1;
        step();
        commit_pulse = 1'b0;
        check("one_issue_valid", 64'(issue_valid), 64'd1);
        check("one_issue_tag", 64'(issue_tag), 64'd0);
        check("one_issue_addr", issue_addr, 64'h0000_0001_0000_1000);
        check("one_issue_len", 64'(issue_len), 64'd3);
        check("one_issue_size", 64'(issue_size), 64'd2);
        check("one_issue_wr", 64'(issue_is_write), 64'd1);
        check("one_free_cnt", 64'(free_cnt), 64'd7);
        step();
        issue_ready = 1'b0;
        check("one_issued", 64'(issue_valid), 64'd0);
        cpl_valid = 1'b1;
        cpl_tag = 3'd0;
        cpl_err = 1'b0;
        step();
        cpl_valid = 1'b0;
        check("one_done_valid", 64'(done_valid), 64'd1);
        check("one_done_tag", 64'(done_tag), 64'd0);
        check("one_done_err", 64'(done_err), 64'd0);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        check("one_free_after", 64'(free_cnt), 64'd8);
        check("one_done_clear", 64'(done_valid), 64'd0);

        // Fill and overflow
        commit_pulse = 1'b1;
        for (int k = 0; k < 8; k++) begin
            addr = {$urandom, $urandom};
            len = 8'($urandom);
            step();
        end
        commit_pulse = 1'b0;
        check("fill_dir_full", 64'(dir_full), 64'd1);
        check("fill_free_cnt", 64'(free_cnt), 64'd0);
        check("fill_head", 64'(issue_tag), 64'd0);
        commit_pulse = 1'b1;
        step();
        commit_pulse = 1'b0;
        check("ovf_drop_pulse", 64'(commit_drop), 64'd1);
        check("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
        check("ovf_free_cnt", 64'(free_cnt), 64'd0);
        step();
        check("ovf_drop_once", 64'(commit_drop), 64'd0);

        // Freed in the same cycle as a commit: commit still dropped, next one takes tag 3
        issue_ready = 1'b1;
        repeat (4) step();
        issue_ready = 1'b0;
        check("sim_head4", 64'(issue_tag), 64'd4);
        cpl_valid = 1'b1;
        cpl_tag = 3'd3;
        cpl_err = 1'b1;
        step();
        cpl_valid = 1'b0;
        check("sim_done_tag", 64'(done_tag), 64'd3);
        check("sim_done_err", 64'(done_err), 64'd1);
        done_ready = 1'b1;
        commit_pulse = 1'b1;
        step();
        done_ready = 1'b0;
        commit_pulse = 1'b0;
        check("sim_dropped", 64'(commit_drop), 64'd1);
        check("sim_drop_cnt", 64'(drop_cnt), 64'd2);
        check("sim_free_cnt", 64'(free_cnt), 64'd1);
        commit_pulse = 1'b1;
        addr = 64'hDEAD_BEEF_0000_0040;
        step();
        commit_pulse = 1'b0;
        check("sim_refull", 64'(dir_full), 64'd1);
        issue_ready = 1'b1;
        repeat (4) step();
        issue_ready = 1'b0;
        check("sim_realloc_tag", 64'(issue_tag), 64'd3);
        check("sim_realloc_addr", issue_addr, 64'hDEAD_BEEF_0000_0040);

        // Reset with entries in mixed states
        cpl_valid = 1'b1;
        cpl_tag = 3'd1;
        cpl_err = 1'b0;
        step();
        cpl_valid = 1'b0;
        presetn = 1'b0;
        #1;
        check("mrst_free_cnt", 64'(free_cnt), 64'd8);
        check("mrst_dir_full", 64'(dir_full), 64'd0);
        check("mrst_issue_valid", 64'(issue_valid), 64'd0);
        check("mrst_done_valid", 64'(done_valid), 64'd0);
        check("mrst_drop_cnt", 64'(drop_cnt), 64'd0);
        step();
        presetn = 1'b1;
        commit_pulse = 1'b1;
        addr = 64'h0000_0000_0000_0100;
        step();
        commit_pulse = 1'b0;
        check("mrst_first_tag", 64'(issue_tag), 64'd0);
        check("mrst_free_cnt7", 64'(free_cnt), 64'd7);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        cpl_valid = 1'b1;
        cpl_tag = 3'd0;
        step();
        cpl_valid = 1'b0;
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;

        // Issue in commit order, done in index order
        commit_pulse = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr = 64'(k + 10);
            step();
        end
        commit_pulse = 1'b0;
        issue_ready = 1'b1;
        check("ord_issue0", 64'(issue_tag), 64'd0);
        step();
        check("ord_issue1", 64'(issue_tag), 64'd1);
        step();
        check("ord_issue2", 64'(issue_tag), 64'd2);
        step();
        issue_ready = 1'b0;
        check("ord_issue_empty", 64'(issue_valid), 64'd0);
        cpl_valid = 1'b1;
        cpl_tag = 3'd2; cpl_err = 1'b0; step();
        cpl_tag = 3'd0; cpl_err = 1'b1; step();
        cpl_tag = 3'd1; cpl_err = 1'b0; step();
        cpl_valid = 1'b0;
        cpl_err = 1'b0;
        check("ord_done0", 64'(done_tag), 64'd0);
        check("ord_err0", 64'(done_err), 64'd1);
        done_ready = 1'b1;
        step();
        check("ord_done1", 64'(done_tag), 64'd1);
        check("ord_err1", 64'(done_err), 64'd0);
        step();
        check("ord_done2", 64'(done_tag), 64'd2);
        check("ord_err2", 64'(done_err), 64'd0);
        step();
        done_ready = 1'b0;
        check("ord_all_free", 64'(free_cnt), 64'd8);

        // Spurious completion on an idle directory
        cpl_valid = 1'b1;
        cpl_tag = 3'd5;
        step();
        cpl_valid = 1'b0;
        check("spur_pulse", 64'(spurious_cpl), 64'd1);
        check("spur_free_cnt", 64'(free_cnt), 64'd8);
        check("spur_no_done", 64'(done_valid), 64'd0);
        step();
        check("spur_once", 64'(spurious_cpl), 64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            commit_pulse = ($urandom_range(0, 99) < 40);
            addr = {$urandom, $urandom};
            len = 8'($urandom);
            size = 3'($urandom);
            is_write = 1'($urandom);
            issue_ready = 1'($urandom);
            cpl_valid = ($urandom_range(0, 99) < 50);
            iss.delete();
            for (int i = 0; i < D; i++) begin
                if (m_state[i] == 2) iss.push_back(i);
            end
            if (iss.size() > 0 && $urandom_range(0, 3) != 0)
                cpl_tag = 3'(iss[$urandom_range(0, iss.size() - 1)]);
            else
                cpl_tag = 3'($urandom);
            cpl_err = 1'($urandom);
            done_ready = ($urandom_range(0, 99) < 40);
            step();
        end
        commit_pulse = 1'b0;
        issue_ready = 1'b0;
        cpl_valid = 1'b0;
        done_ready = 1'b0;

        // Drop counter saturation
        presetn = 1'b0;
        step();
        presetn = 1'b1;
        commit_pulse = 1'b1;
        repeat (8 + 260) step();
        commit_pulse = 1'b0;
        step();
        check("sat_drop_cnt", 64'(drop_cnt), 64'd255);
        check("sat_dir_full", 64'(dir_full), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/apb2axi_dir.md
# apb2axi_dir

Transaction directory for the APB-to-AXI bridge. Captures each command committed by the APB register file (single-cycle `commit_pulse` with `addr`/`len`/`size`/`is_write`) into a DEPTH-entry tagged table. Entries are issued in commit order to the AXI command builder over a valid/ready interface. Each entry is then tracked until the AXI response side reports completion for its tag, and the final status is handed to the status/readback path.

## Interface
- AXI_ADDR_W, 64, command address width.
- DEPTH, 8, number of directory entries; power of two, at least 2.
- TAG_W, $clog2(DEPTH), tag width.

- pclk  in  1  clock. One clock for the whole block.
- presetn  in  1  reset, asynchronous, active-low.
- commit_pulse  in  1  one-cycle command commit from the register file.
- addr  in  AXI_ADDR_W  command address; sampled when commit_pulse=1.
- len  in  8  AXI burst length minus one.
- size  in  3  AXI beat size code.
- is_write  in  1  1 = write, 0 = read.
- dir_full  out  1  no FREE entry (registered state).
- commit_drop  out  1  one-cycle pulse: a commit was rejected.
- drop_cnt  out  8  saturating count of rejected commits.
- free_cnt  out  TAG_W+1  number of FREE entries.
- issue_valid  out  1  a PENDING command is offered downstream.
- issue_ready  in  1  the AXI command builder accepts.
- issue_tag  out  TAG_W  entry index of the offered command.
- issue_addr / issue_len / issue_size / issue_is_write  out  AXI_ADDR_W/8/3/1  stored fields of the offered entry.
- cpl_valid  in  1  completion strobe from the AXI response side.
- cpl_tag  in  TAG_W  tag being completed.
- cpl_err  in  1  1 = SLVERR/DECERR seen on that transaction.
- spurious_cpl  out  1  one-cycle pulse: the completion tag was not in ISSUED.
- done_valid  out  1  at least one entry is DONE.
- done_ready  in  1  the status path consumes the offered DONE entry.
- done_tag  out  TAG_W  lowest-index DONE entry.
- done_err  out  1  stored error flag of done_tag.

## Operation
- Each entry has a 2-bit state:
  - FREE → PENDING on commit.
  - PENDING → ISSUED on an issue handshake.
  - ISSUED → DONE on a valid completion.
  - DONE → FREE on a done handshake.
  - No other transitions.
- **Allocation:** a commit with dir_full=0 writes the lowest-index FREE entry. It stores addr, len, size and is_write, clears the err flag, and pushes the tag into an in-order issue FIFO (DEPTH deep). The FIFO cannot overflow.
- **Full:** a commit with dir_full=1 is dropped.
  - commit_drop pulses on the next cycle.
  - drop_cnt increments and holds at 255.
  - The table is unchanged.
  - dir_full is evaluated on registered state, so an entry freed in the same cycle does not admit the commit.
- **Issue:**
  - issue_valid = issue FIFO not empty.
  - issue_tag is the FIFO head; the issue_* fields are read combinationally from the table at that head.
  - On issue_valid && issue_ready the head pops and the entry moves to ISSUED.
  - Once issue_valid is high, it and all issue_* fields stay stable until the handshake.
- **Completion:**
  - cpl_valid with cpl_tag in ISSUED moves that entry to DONE and stores err = cpl_err.
  - Any other state leaves the table unchanged and pulses spurious_cpl on the next cycle.
- **Done:**
  - done_valid = any DONE entry. done_tag is the lowest DONE index; done_err is its flag.
  - On done_valid && done_ready the entry becomes FREE.
  - A completion landing on a lower index while done_valid is high may change done_tag only on a cycle where done_ready=0.
- **Simultaneous events:** commit, issue handshake, completion and done handshake on different entries all take effect in the same cycle. free_cnt reflects the net change.
- **Reset** (asynchronous, mid-operation included):
  - All entries FREE and the FIFO empty.
  - drop_cnt = 0; free_cnt = DEPTH.
  - All other outputs are 0, including dir_full, commit_drop, spurious_cpl, issue_valid and done_valid.

## Timing
- Commit at clock edge t → issue_valid = 1 in the cycle after edge t (1-cycle latency) when the FIFO was empty.
- Back-to-back commits on consecutive cycles are all accepted while entries remain.
- With issue_ready held at 1, one command issues per cycle.
- Completion at edge t → done_valid in the cycle after t.
- Done handshake at edge t → entry FREE and free_cnt updated after t; it can be reallocated by a commit at edge t+1.
- dir_full, free_cnt, commit_drop, drop_cnt and spurious_cpl are all registered.

## Test plan
- **Single command:** reset, then commit addr=0x0000_0001_0000_1000, len=3, size=2, is_write=1 with issue_ready=1.
  - Next cycle: issue_valid=1, tag=0, fields match.
  - Then cpl_tag=0, cpl_err=0 → done_valid=1, done_tag=0, done_err=0.
  - After done_ready: free_cnt=8.
- **Fill and overflow:** 8 commits with issue_ready=0 → dir_full=1, free_cnt=0. A 9th commit → commit_drop pulses, drop_cnt=1, table unchanged.
- **Order:** commits A, B, C; complete tags 2, 0, 1 with cpl_err on tag 0 → issue order is 0, 1, 2; done order is 0 (err=1), 1, 2.
- **Spurious completion:** cpl_tag=5 on an idle directory → spurious_cpl=1 for one cycle; no state change.
- **Simultaneous events:** full directory; in one cycle apply a done handshake on tag 3 and a commit → commit dropped. A commit on the next cycle is allocated tag 3.
- **Reset mid-flight:** presetn low with 4 entries in mixed states → outputs 0 immediately, free_cnt=8 after release, and the first commit gets tag 0.
